hex_scan_controller: RTL and testbench

- Time-multiplexed scan controller for a common-anode multi-digit seven-segment display.
- Accepts a packed hex word (e.g. a register or PC value from the core) through a valid/ready handshake and buffers it.
- Each digit is presented in turn as a 4-bit nibble to the downstream seven_seg_driver, with an active-low digit enable.
- Adds leading-zero blanking, anti-ghosting guard gaps and tear-free frame-boundary updates.

---
 rtl/hex_scan_controller.sv | 109 ++++++++++
 tb/tb_hex_scan_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_controller.sv
// hex_scan_controller: time-multiplexed scan of a buffered hex word onto a common-anode seven-segment display.
// Ports: clk, reset_n (async, active-low); load_valid/load_data/load_ready accept a packed hex word
// (nibble i = digit i, digit 0 least significant); nibble, digit_en_n (active-low one-hot), digit_idx
// and frame_start (pulse on the first dwell cycle of digit 0) drive the downstream seven_seg_driver.
module hex_scan_controller #(
    parameter int NUM_DIGITS   = 8,
    parameter int DWELL_CYCLES = 50000,
    parameter int GUARD_CYCLES = 2,
    parameter int BLANK_LZ     = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    output logic [3:0]              nibble,
    output logic [NUM_DIGITS-1:0]   digit_en_n,
    output logic [2:0]              digit_idx,
    output logic                    frame_start
);
    localparam int W    = 4 * NUM_DIGITS;
    localparam int CMAX = DWELL_CYCLES > GUARD_CYCLES ? DWELL_CYCLES : GUARD_CYCLES;
    localparam int CW   = $clog2(CMAX) + 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE = NUM_DIGITS'(1);
    typedef enum logic [1:0] {IDLE, DWELL, GUARD} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0] idx_nx;
    logic [W-1:0] disp_reg, pend_reg, disp_nx, nib_sh;
    logic pending_valid, accept, commit, wrap, acc, lit, fs_nx;
    logic [NUM_DIGITS-1:0] keep, sel, en_nx;
    logic [3:0] nib_nx;
    assign load_ready = ~pending_valid;
    assign accept     = load_valid & ~pending_valid;
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = digit_idx;
        wrap     = 1'b0;
        case (state)
            IDLE: begin
                if (pending_valid) begin
                    state_nx = DWELL;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            end
            DWELL: begin
                state_nx = cnt == DWELL_LAST ? GUARD : DWELL;
                cnt_nx   = cnt == DWELL_LAST ? '0 : cnt + 1'b1;
            end
            GUARD: begin
                if (cnt == GUARD_LAST) begin
                    state_nx = DWELL;
                    cnt_nx   = '0;
                    wrap     = digit_idx == LAST_IDX;
                    idx_nx   = wrap ? 3'd0 : digit_idx + 3'd1;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        // disp_reg only changes between frames, so a frame is never torn.
        commit  = pending_valid & ((state == IDLE) | wrap);
        disp_nx = commit ? pend_reg : disp_reg;
    end
    // keep[i]: digit i shows, i.e. it is digit 0, blanking is off, or a nonzero nibble sits at or above i.
    always_comb begin
        keep = '0;
        acc  = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc     = acc | (disp_nx[4*i +: 4] != 4'h0);
            keep[i] = acc | (i == 0) | (BLANK_LZ == 0);
        end
        sel    = ONE << idx_nx;
        lit    = |(keep & sel);
        nib_sh = disp_nx >> {idx_nx, 2'b00};
        en_nx  = (state_nx == DWELL && lit) ? ~sel : '1;
        nib_nx = state_nx == DWELL ? nib_sh[3:0] : nibble;
        fs_nx  = state_nx == DWELL && state != DWELL && idx_nx == 3'd0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            digit_idx     <= '0;
            disp_reg      <= '0;
            pend_reg      <= '0;
            pending_valid <= 1'b0;
            digit_en_n    <= '1;
            nibble        <= '0;
            frame_start   <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            digit_idx     <= idx_nx;
            disp_reg      <= disp_nx;
            pend_reg      <= accept ? load_data : pend_reg;
            pending_valid <= accept | (pending_valid & ~commit);
            digit_en_n    <= en_nx;
            nibble        <= nib_nx;
            frame_start   <= fs_nx;
        end
    end
endmodule

// File: tb/tb_hex_scan_controller.sv
// tb_hex_scan_controller: directed checks of scan timing, blanking, buffering and reset.
module tb_hex_scan_controller;
    logic clk = 1'b0;
    logic reset_n, load_valid;
    logic [15:0] load_data;
    logic load_ready, frame_start, load_ready0, frame_start0;
    logic [3:0] nibble, digit_en_n, nibble0, digit_en_n0;
    logic [2:0] digit_idx, digit_idx0;
    int checks = 0;
    int errors = 0;
    typedef struct {
        logic lv;
        logic [15:0] data;
        logic rdy;
        logic [3:0] en;
        logic [3:0] nib;
        logic [2:0] idx;
        logic fs;
    } vec_t;
    vec_t tbl[23];
    hex_scan_controller #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .GUARD_CYCLES(1), .BLANK_LZ(1)) dut (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .nibble(nibble), .digit_en_n(digit_en_n),
        .digit_idx(digit_idx), .frame_start(frame_start));
    hex_scan_controller #(.NUM_DIGITS(4), .DWELL_CYCLES(4), .GUARD_CYCLES(1), .BLANK_LZ(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready0), .nibble(nibble0), .digit_en_n(digit_en_n0),
        .digit_idx(digit_idx0), .frame_start(frame_start0));
    always #5 clk = ~clk;
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [3:0] exp_en(input int d, input int slot, input logic [3:0] mask);
        exp_en = (slot < 4 && mask[d]) ? ~(4'b0001 << d) : 4'hF;
    endfunction
    task automatic do_load(input logic [15:0] v);
        chk("ready_before_load", load_ready, 1);
        load_valid = 1'b1;
        load_data  = v;
        step();
        load_valid = 1'b0;
        chk("ready_after_load", load_ready, 0);
    endtask
    task automatic wait_fs();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (frame_start) found = 1'b1;
            else step();
        end
        chk("wait_frame_start", found, 1);
    endtask
    // Checks one full 20-cycle frame from its frame_start cycle; ends on the next frame_start cycle.
    task automatic check_frame(input logic [15:0] v, input logic [3:0] m1, input logic [3:0] m0);
        for (int d = 0; d < 4; d++)
            for (int s = 0; s < 5; s++) begin
                chk("frame_en", digit_en_n, exp_en(d, s, m1));
                chk("frame_nib", nibble, v[4*d +: 4]);
                chk("frame_idx", digit_idx, d);
                chk("frame_fs", frame_start, (d == 0 && s == 0));
                chk("frame_en_nolz", digit_en_n0, exp_en(d, s, m0));
                chk("frame_nib_nolz", nibble0, v[4*d +: 4]);
                step();
                load_valid = 1'b0;
            end
    endtask
    initial begin
        logic ok;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", digit_en_n, 4'hF);
        chk("rst_nib", nibble, 0);
        chk("rst_idx", digit_idx, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_ready", load_ready, 1);
        reset_n = 1'b1;
        step();
        tbl[0]  = '{1'b1, 16'h1A2F, 1'b1, 4'hF, 4'h0, 3'd0, 1'b0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 4'hF, 4'h0, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b1, 4'hE, 4'hF, 3'd0, 1'b1};
        tbl[3]  = '{1'b0, 16'h0000, 1'b1, 4'hE, 4'hF, 3'd0, 1'b0};
        tbl[4]  = '{1'b0, 16'h0000, 1'b1, 4'hE, 4'hF, 3'd0, 1'b0};
        tbl[5]  = '{1'b0, 16'h0000, 1'b1, 4'hE, 4'hF, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 16'h0000, 1'b1, 4'hF, 4'hF, 3'd0, 1'b0};
        tbl[7]  = '{1'b0, 16'h0000, 1'b1, 4'hD, 4'h2, 3'd1, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 1'b1, 4'hD, 4'h2, 3'd1, 1'b0};
        tbl[9]  = '{1'b0, 16'h0000, 1'b1, 4'hD, 4'h2, 3'd1, 1'b0};
        tbl[10] = '{1'b0, 16'h0000, 1'b1, 4'hD, 4'h2, 3'd1, 1'b0};
        tbl[11] = '{1'b0, 16'h0000, 1'b1, 4'hF, 4'h2, 3'd1, 1'b0};
        tbl[12] = '{1'b0, 16'h0000, 1'b1, 4'hB, 4'hA, 3'd2, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 4'hB, 4'hA, 3'd2, 1'b0};
        tbl[14] = '{1'b0, 16'h0000, 1'b1, 4'hB, 4'hA, 3'd2, 1'b0};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 4'hB, 4'hA, 3'd2, 1'b0};
        tbl[16] = '{1'b0, 16'h0000, 1'b1, 4'hF, 4'hA, 3'd2, 1'b0};
        tbl[17] = '{1'b0, 16'h0000, 1'b1, 4'h7, 4'h1, 3'd3, 1'b0};
        tbl[18] = '{1'b0, 16'h0000, 1'b1, 4'h7, 4'h1, 3'd3, 1'b0};
        tbl[19] = '{1'b0, 16'h0000, 1'b1, 4'h7, 4'h1, 3'd3, 1'b0};
        tbl[20] = '{1'b0, 16'h0000, 1'b1, 4'h7, 4'h1, 3'd3, 1'b0};
        tbl[21] = '{1'b0, 16'h0000, 1'b1, 4'hF, 4'h1, 3'd3, 1'b0};
        tbl[22] = '{1'b0, 16'h0000, 1'b1, 4'hE, 4'hF, 3'd0, 1'b1};
        for (int i = 0; i < 23; i++) begin
            load_valid = tbl[i].lv;
            load_data  = tbl[i].data;
            chk("tbl_ready", load_ready, tbl[i].rdy);
            chk("tbl_en", digit_en_n, tbl[i].en);
            chk("tbl_nib", nibble, tbl[i].nib);
            chk("tbl_idx", digit_idx, tbl[i].idx);
            chk("tbl_fs", frame_start, tbl[i].fs);
            chk("tbl_en_nolz", digit_en_n0, tbl[i].en);
            step();
        end
        do_load(16'h0030);
        wait_fs();
        check_frame(16'h0030, 4'b0011, 4'b1111);
        do_load(16'h0000);
        wait_fs();
        check_frame(16'h0000, 4'b0001, 4'b1111);
        do_load(16'h1A2F);
        wait_fs();
        repeat (5) step();
        chk("mid_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = 16'h5555;
        step();
        load_data = 16'h0777;
        for (int c = 6; c < 20; c++) begin
            chk("mid_ready_busy", load_ready, 0);
            chk("mid_en_old", digit_en_n, exp_en(c / 5, c % 5, 4'b1111));
            chk("mid_nib_old", nibble, 16'h1A2F >> (4 * (c / 5)) & 16'hF);
            step();
        end
        chk("wrap_ready", load_ready, 1);
        check_frame(16'h5555, 4'b1111, 4'b1111);
        check_frame(16'h0777, 4'b0111, 4'b1111);
        repeat (19) step();
        chk("edge_ready", load_ready, 1);
        load_valid = 1'b1;
        load_data  = 16'hBEEF;
        step();
        load_valid = 1'b0;
        chk("edge_ready_after", load_ready, 0);
        check_frame(16'h0777, 4'b0111, 4'b1111);
        check_frame(16'hBEEF, 4'b1111, 4'b1111);
        repeat (9) step();
        do_load(16'h1234);
        chk("pre_rst_en", digit_en_n, 4'hB);
        reset_n = 1'b0;
        #1;
        chk("async_rst_en", digit_en_n, 4'hF);
        chk("async_rst_ready", load_ready, 1);
        chk("async_rst_nib", nibble, 0);
        chk("async_rst_idx", digit_idx, 0);
        repeat (2) step();
        reset_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (digit_en_n !== 4'hF || frame_start !== 1'b0 || load_ready !== 1'b1) ok = 1'b0;
        end
        chk("idle_after_rst", ok, 1);
        do_load(16'h0042);
        step();
        chk("reload_fs", frame_start, 1);
        check_frame(16'h0042, 4'b0011, 4'b1111);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
